traf_light_param: RTL
=====================

Name: traf_light_param

Overview:
Parametrised successor to the fixed four-way traffic light controller. Drives NUM_DIR approaches round-robin through GREEN, YELLOW and ALL_RED phases. All phase durations are whole "ticks" from an internal prescaler. Adds demand-actuated skipping and green hold from vehicle request inputs, plus a night flash mode.

Parameters:
NUM_DIR, 4, number of approaches (>=2)
TICK_DIV, 50000000, clk cycles per tick (1 s at 50 MHz)
GREEN_T, 10, green duration in ticks (>=1)
YELLOW_T, 3, yellow duration in ticks (>=1)
ALLRED_T, 1, all-red clearance in ticks (>=1)
CNT_W, 8, phase timer width; must hold max(GREEN_T, YELLOW_T, ALLRED_T)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
demand_en  in  1  1 = demand-actuated mode, 0 = fixed-time round robin
req  in  NUM_DIR  per-approach vehicle request level; synchronous to clk, synchronisers live outside this block
flash  in  1  night flash request level; synchronous to clk
light  out  2*NUM_DIR  approach i on [2i+1:2i]; 00 RED, 01 GREEN, 10 YELLOW, 11 OFF
cur_dir  out  clog2(NUM_DIR)  approach currently owning or last owning green
phase  out  2  00 ALL_RED, 01 GREEN, 10 YELLOW, 11 FLASH

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - phase=ALL_RED, all light=00, cur_dir=NUM_DIR-1 (so first green is approach 0).
  - Timer=ALLRED_T, prescaler=0.
- Prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1. It clears on every phase transition, so every phase lasts exactly duration*TICK_DIV cycles.
- Timer: decrements on tick. Expiry = tick while timer==1. The transition is registered at that edge, and outputs are registered alongside phase (no extra latency).
- ALL_RED expiry, checked in priority order:
  1. flash=1: go to FLASH.
  2. demand_en=0: next = (cur_dir+1) mod NUM_DIR.
  3. demand_en=1: next = first i with req[i]=1, searching cyclically from cur_dir+1 (cur_dir itself searched last).
  4. demand_en=1 and req=0: stay in ALL_RED, reload ALLRED_T.
  On a move to GREEN, cur_dir=next and timer=GREEN_T.
- GREEN expiry:
  - demand_en=1 and req with bit cur_dir masked off is zero: hold GREEN and reload GREEN_T.
  - Otherwise go to YELLOW with timer=YELLOW_T.
  - flash does not cut green short.
- YELLOW expiry: go to ALL_RED with timer=ALLRED_T.
- FLASH:
  - All approaches show 10 for one tick, then 11 for one tick, alternating. The first tick shows yellow.
  - On a tick where flash=0: go to ALL_RED with timer=ALLRED_T; cur_dir is unchanged.
- Invariant: outside FLASH, at most one approach is non-RED; the green/yellow approach is always cur_dir.
- req and flash are sampled only at expiry points; pulses between expiries are ignored.
- NUM_DIR not a power of two: cur_dir wraps NUM_DIR-1 to 0; the unused encodings are never produced.

Decomposition:
- traf_light_pkg holds:
  - phase enum (ALL_RED, GREEN, YELLOW, FLASH);
  - light encoding constants (L_RED, L_GREEN, L_YELLOW, L_OFF);
  - a function for the cyclic next-request search.
- One sub-module, tick_prescaler (params TICK_DIV; ports clk, reset, clr, tick).
- The FSM, timer and output decode stay in traf_light_param.

Test Plan:
Common parameters NUM_DIR=4, TICK_DIV=4, GREEN_T=3, YELLOW_T=2, ALLRED_T=1; cycle 0 = first edge after reset falls.
1. demand_en=0, flash=0 -> light=all 00 until cycle 4; approach0=01 cycles 4-15, 10 cycles 16-23; all red 24-27; approach1=01 from cycle 28; order 0,1,2,3,0.
2. demand_en=1, req=0100 -> approach2 green at cycle 4 and held indefinitely. Set req=0101 -> at next green expiry approach2 goes yellow, then all red, then approach0 green.
3. demand_en=1, req=0000 -> phase stays 00, light all 00, for >=100 cycles.
4. flash=1 raised during approach1 green -> green, yellow and all red complete normally, then FLASH: light=all 10 for 4 cycles, all 11 for 4 cycles, repeating. Drop flash -> ALL_RED for 4 cycles, then approach2 green.
5. Reset asserted mid-YELLOW, between edges -> light=all 00 immediately; after release, approach0 is green at cycle 4.
6. NUM_DIR=3, demand_en=0 -> green sequence 0,1,2,0; light width 6; cur_dir never reaches 3.

Source files
------------

// File: rtl/traf_light_pkg.sv
// Shared types, light encodings and the cyclic request search used by the
// parametrised traffic light controller.
package traf_light_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10,
    PH_FLASH   = 2'b11
  } phase_t;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_OFF    = 2'b11;

  // Widest request vector the search helper accepts.
  localparam int MAX_DIR = 32;

  // First requesting approach after cur, wrapping, with cur itself tried last.
  // Returns -1 when nothing is requesting. Walking k downward lets the
  // smallest offset win without an early exit.
  function automatic int next_req(input logic [MAX_DIR-1:0] req,
                                  input int num_dir,
                                  input int cur);
    int idx;
    int result;
    result = -1;
    for (int k = MAX_DIR; k >= 1; k--) begin
      if (k <= num_dir) begin
        idx = cur + k;
        if (idx >= num_dir) idx = idx - num_dir;
        if (req[idx]) result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick generator: one-cycle pulse every TICK_DIV clocks,
// restartable so a new phase always begins on a fresh tick period.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/traf_light_param.sv
// Round-robin / demand-actuated traffic light controller for NUM_DIR approaches
// with a night flash mode. All phase timing is counted in prescaler ticks.
module traf_light_param
  import traf_light_pkg::*;
#(
  parameter int NUM_DIR  = 4,
  parameter int TICK_DIV = 50000000,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       demand_en,
  input  logic [NUM_DIR-1:0]         req,
  input  logic                       flash,
  output logic [2*NUM_DIR-1:0]       light,
  output logic [$clog2(NUM_DIR)-1:0] cur_dir,
  output logic [1:0]                 phase
);

  localparam int DIR_W = $clog2(NUM_DIR);

  phase_t               phase_reg;
  logic [CNT_W-1:0]     timer_reg;
  logic [DIR_W-1:0]     cur_dir_reg;
  logic                 flash_yel_reg;
  logic [2*NUM_DIR-1:0] light_reg;

  logic             tick;
  logic             expire;
  logic             timer_at_one;
  logic [DIR_W-1:0] rr_next;
  logic [DIR_W-1:0] next_dir;
  logic             found;
  logic             others_req;
  int               search_idx;

  function automatic logic [2*NUM_DIR-1:0] one_lit(input logic [DIR_W-1:0] dir,
                                                   input logic [1:0] code);
    logic [2*NUM_DIR-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (dir == DIR_W'(i)) l[2*i +: 2] = code;
    end
    return l;
  endfunction

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (expire),
    .tick  (tick)
  );

  // FLASH has no timer: it ends on any tick that finds flash released.
  assign timer_at_one = (timer_reg == CNT_W'(1));
  assign expire = tick && ((phase_reg == PH_FLASH) ? !flash : timer_at_one);

  always_comb begin
    rr_next    = (cur_dir_reg == DIR_W'(NUM_DIR - 1)) ? '0 : cur_dir_reg + 1'b1;
    search_idx = next_req(MAX_DIR'(req), NUM_DIR, int'(cur_dir_reg));
    found      = (search_idx >= 0);
    next_dir   = demand_en ? DIR_W'(search_idx) : rr_next;
    others_req = |(req & ~(NUM_DIR'(1) << cur_dir_reg));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg     <= PH_ALL_RED;
      timer_reg     <= CNT_W'(ALLRED_T);
      cur_dir_reg   <= DIR_W'(NUM_DIR - 1);
      flash_yel_reg <= 1'b0;
      light_reg     <= {NUM_DIR{L_RED}};
    end else if (tick) begin
      case (phase_reg)
        PH_ALL_RED: begin
          if (!timer_at_one) begin
            timer_reg <= timer_reg - 1'b1;
          end else if (flash) begin
            phase_reg     <= PH_FLASH;
            flash_yel_reg <= 1'b1;
            light_reg     <= {NUM_DIR{L_YELLOW}};
          end else if (!demand_en || found) begin
            phase_reg   <= PH_GREEN;
            cur_dir_reg <= next_dir;
            timer_reg   <= CNT_W'(GREEN_T);
            light_reg   <= one_lit(next_dir, L_GREEN);
          end else begin
            timer_reg <= CNT_W'(ALLRED_T);
          end
        end
        PH_GREEN: begin
          if (!timer_at_one) begin
            timer_reg <= timer_reg - 1'b1;
          end else if (demand_en && !others_req) begin
            timer_reg <= CNT_W'(GREEN_T);
          end else begin
            phase_reg <= PH_YELLOW;
            timer_reg <= CNT_W'(YELLOW_T);
            light_reg <= one_lit(cur_dir_reg, L_YELLOW);
          end
        end
        PH_YELLOW: begin
          if (!timer_at_one) begin
            timer_reg <= timer_reg - 1'b1;
          end else begin
            phase_reg <= PH_ALL_RED;
            timer_reg <= CNT_W'(ALLRED_T);
            light_reg <= {NUM_DIR{L_RED}};
          end
        end
        default: begin
          if (!flash) begin
            phase_reg     <= PH_ALL_RED;
            timer_reg     <= CNT_W'(ALLRED_T);
            flash_yel_reg <= 1'b0;
            light_reg     <= {NUM_DIR{L_RED}};
          end else begin
            flash_yel_reg <= !flash_yel_reg;
            light_reg     <= flash_yel_reg ? {NUM_DIR{L_OFF}} : {NUM_DIR{L_YELLOW}};
          end
        end
      endcase
    end
  end

  assign light   = light_reg;
  assign cur_dir = cur_dir_reg;
  assign phase   = phase_reg;

endmodule
